// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;
endpackage

// File: rtl/reg_file_multi_if.sv
// Operand-fetch port bundle: write request, two read addresses, flag control, sweep control.
interface reg_file_multi_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              enableWrite;
    logic [ADDR_W-1:0] registerA;
    logic [ADDR_W-1:0] registerB;
    logic [ADDR_W-1:0] registerWrite;
    logic [DATA_W-1:0] dataIn;
    logic              flag;
    logic              flagClear;
    logic              clearAll;
    logic [DATA_W-1:0] regA;
    logic [DATA_W-1:0] regB;
    logic              flagBit;
    logic              busy;
    logic              writeDropped;

    modport master (
        output enableWrite, registerA, registerB, registerWrite, dataIn,
               flag, flagClear, clearAll,
        input  regA, regB, flagBit, busy, writeDropped
    );

    modport slave (
        input  enableWrite, registerA, registerB, registerWrite, dataIn,
               flag, flagClear, clearAll,
        output regA, regB, flagBit, busy, writeDropped
    );
endinterface

// File: rtl/reg_file_multi_clear_sequencer.sv
// Background clear-all sweep: walks every entry once, one per cycle, and reports busy.
module clear_sequencer
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              start_i,
    output logic              busy_o,
    output logic              clr_en_o,
    output logic [ADDR_W-1:0] clr_addr_o
);
    sweep_state_t      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter parks on the last entry after a sweep; a new sweep reloads it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (cnt_q == '1) state_d = IDLE;
                else             cnt_d   = ADDR_W'(cnt_q + 1'b1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o     = (state_q == SWEEP);
    assign clr_en_o   = (state_q == SWEEP);
    assign clr_addr_o = cnt_q;
endmodule

// File: rtl/reg_file_multi.sv
// Parametrised 2R/1W register file with optional zero register, write bypass,
// sticky flag and a background clear-all sweep.
module reg_file_multi
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clock,
    input  logic             resetN,
    reg_file_multi_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic                         flag_q;
    logic                         drop_q;
    logic                         busy;
    logic                         clr_en;
    logic [ADDR_W-1:0]            clr_addr;
    logic                         wr_acc;

    clear_sequencer #(.ADDR_W(ADDR_W)) u_seq (
        .clock      (clock),
        .resetN     (resetN),
        .start_i    (bus.clearAll),
        .busy_o     (busy),
        .clr_en_o   (clr_en),
        .clr_addr_o (clr_addr)
    );

    assign wr_acc = bus.enableWrite && !busy &&
                    !(ZERO_REG && (bus.registerWrite == '0));

    // Sweep and user write are mutually exclusive: wr_acc already requires !busy.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mem_q <= '0;
        end else if (clr_en) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem_q[bus.registerWrite] <= bus.dataIn;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            flag_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            if (bus.flag)           flag_q <= 1'b1;
            else if (bus.flagClear) flag_q <= 1'b0;
            drop_q <= bus.enableWrite && busy;
        end
    end

    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        if (ZERO_REG && (a == '0))                          return '0;
        else if (BYPASS && wr_acc && (a == bus.registerWrite)) return bus.dataIn;
        else                                                return mem_q[a];
    endfunction

    assign bus.regA         = rd(bus.registerA);
    assign bus.regB         = rd(bus.registerB);
    assign bus.flagBit      = flag_q;
    assign bus.busy         = busy;
    assign bus.writeDropped = drop_q;
endmodule

// File: tb/tb_reg_file_multi.sv
// Directed bench for reg_file_multi: three builds (default, no-bypass, zero-reg)
// driven in lockstep, checked against a queue of expected values.
module tb_reg_file_multi;
    logic clock = 1'b0;
    logic resetN;

    always #5 clock = ~clock;

    reg_file_multi_if #(.DATA_W(8), .ADDR_W(3)) if0 ();
    reg_file_multi_if #(.DATA_W(8), .ADDR_W(3)) if1 ();
    reg_file_multi_if #(.DATA_W(8), .ADDR_W(3)) if2 ();

    assign if1.enableWrite   = if0.enableWrite;
    assign if1.registerA     = if0.registerA;
    assign if1.registerB     = if0.registerB;
    assign if1.registerWrite = if0.registerWrite;
    assign if1.dataIn        = if0.dataIn;
    assign if1.flag          = if0.flag;
    assign if1.flagClear     = if0.flagClear;
    assign if1.clearAll      = if0.clearAll;
    assign if2.enableWrite   = if0.enableWrite;
    assign if2.registerA     = if0.registerA;
    assign if2.registerB     = if0.registerB;
    assign if2.registerWrite = if0.registerWrite;
    assign if2.dataIn        = if0.dataIn;
    assign if2.flag          = if0.flag;
    assign if2.flagClear     = if0.flagClear;
    assign if2.clearAll      = if0.clearAll;

    reg_file_multi #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b1))
        dut    (.clock(clock), .resetN(resetN), .bus(if0));
    reg_file_multi #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0))
        dut_nb (.clock(clock), .resetN(resetN), .bus(if1));
    reg_file_multi #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dut_z  (.clock(clock), .resetN(resetN), .bus(if2));

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        if0.enableWrite   = 1'b1;
        if0.registerWrite = a;
        if0.dataIn        = d;
        tick();
        if0.enableWrite   = 1'b0;
    endtask

    int busy_cnt;

    initial begin
        resetN            = 1'b0;
        if0.enableWrite   = 1'b0;
        if0.registerA     = '0;
        if0.registerB     = '0;
        if0.registerWrite = '0;
        if0.dataIn        = '0;
        if0.flag          = 1'b0;
        if0.flagClear     = 1'b0;
        if0.clearAll      = 1'b0;
        #12;
        // reset state
        push("rst_busy", 0);  chk(32'(if0.busy));
        push("rst_flag", 0);  chk(32'(if0.flagBit));
        push("rst_drop", 0);  chk(32'(if0.writeDropped));
        for (int i = 0; i < 8; i++) begin
            if0.registerA = 3'(i);
            #1;
            push($sformatf("rst_r%0d", i), 0); chk(32'(if0.regA));
        end
        resetN = 1'b1;
        tick();

        // 1: basic write then read
        if0.registerA = 3'd1;
        if0.registerB = 3'd0;
        wr(3'd1, 8'hCA);
        #1;
        push("t1_regA", 8'hCA); chk(32'(if0.regA));
        push("t1_regB", 8'h00); chk(32'(if0.regB));

        // 2: bypass versus no bypass
        if0.enableWrite   = 1'b1;
        if0.registerWrite = 3'd4;
        if0.dataIn        = 8'h56;
        if0.registerA     = 3'd4;
        if0.registerB     = 3'd4;
        #1;
        push("t2_byp_A", 8'h56);  chk(32'(if0.regA));
        push("t2_byp_B", 8'h56);  chk(32'(if0.regB));
        push("t2_nob_A", 8'h00);  chk(32'(if1.regA));
        push("t2_nob_B", 8'h00);  chk(32'(if1.regB));
        tick();
        if0.enableWrite = 1'b0;
        #1;
        push("t2_nob_after", 8'h56); chk(32'(if1.regA));

        // 3: zero register
        if0.enableWrite   = 1'b1;
        if0.registerWrite = 3'd0;
        if0.dataIn        = 8'hFF;
        if0.registerA     = 3'd0;
        #1;
        push("t3_z_r0_byp", 8'h00); chk(32'(if2.regA));
        tick();
        if0.enableWrite = 1'b0;
        #1;
        push("t3_z_r0", 8'h00);  chk(32'(if2.regA));
        push("t3_z_drop", 0);    chk(32'(if2.writeDropped));
        wr(3'd2, 8'hFF);
        if0.registerA = 3'd2;
        #1;
        push("t3_z_r2", 8'hFF);  chk(32'(if2.regA));

        // 4: sticky flag
        if0.flag = 1'b1;
        tick();
        if0.flag = 1'b0;
        #1;
        push("t4_set", 1);   chk(32'(if0.flagBit));
        tick();
        push("t4_hold", 1);  chk(32'(if0.flagBit));
        if0.flag      = 1'b1;
        if0.flagClear = 1'b1;
        tick();
        if0.flag      = 1'b0;
        if0.flagClear = 1'b0;
        #1;
        push("t4_setwins", 1); chk(32'(if0.flagBit));
        if0.flagClear = 1'b1;
        tick();
        if0.flagClear = 1'b0;
        #1;
        push("t4_clear", 0); chk(32'(if0.flagBit));

        // 5: fill and sweep
        for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h10 + i));
        if0.registerA = 3'd7;
        #1;
        push("t5_prefill_r7", 8'h17); chk(32'(if0.regA));
        if0.clearAll = 1'b1;
        tick();
        if0.clearAll = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) begin
                if0.registerA = 3'd7;
                #1;
                push("t5_mid_r7", 8'h17); chk(32'(if0.regA));
            end
            if (c == 3) begin
                if0.enableWrite   = 1'b1;
                if0.registerWrite = 3'd6;
                if0.dataIn        = 8'hAA;
                if0.registerA     = 3'd6;
                #1;
                push("t5_nobyp_busy", 8'h16); chk(32'(if0.regA));
            end
            if (c == 4) begin
                if0.enableWrite = 1'b0;
                if0.clearAll    = 1'b1;
                #1;
                push("t5_drop_pulse", 1); chk(32'(if0.writeDropped));
                push("t5_r6_kept", 8'h16); chk(32'(if0.regA));
            end
            if (c == 5) begin
                if0.clearAll = 1'b0;
                #1;
                push("t5_drop_once", 0); chk(32'(if0.writeDropped));
            end
            if (if0.busy) busy_cnt++;
            tick();
        end
        push("t5_busy_cycles", 8); chk(32'(busy_cnt));
        for (int i = 0; i < 8; i++) begin
            if0.registerA = 3'(i);
            if0.registerB = 3'(7 - i);
            #1;
            push($sformatf("t5_clrA_r%0d", i), 0); chk(32'(if0.regA));
            push($sformatf("t5_clrB_r%0d", 7 - i), 0); chk(32'(if0.regB));
        end

        // 6: reset mid-sweep
        wr(3'd5, 8'h55);
        wr(3'd2, 8'h22);
        if0.clearAll = 1'b1;
        tick();
        if0.clearAll = 1'b0;
        tick();
        tick();
        tick();
        resetN = 1'b0;
        #1;
        push("t6_busy_rst", 0); chk(32'(if0.busy));
        if0.registerA = 3'd5;
        if0.registerB = 3'd2;
        #1;
        push("t6_r5_rst", 0); chk(32'(if0.regA));
        push("t6_r2_rst", 0); chk(32'(if0.regB));
        resetN = 1'b1;
        tick();
        wr(3'd5, 8'h5A);
        #1;
        push("t6_r5_after", 8'h5A); chk(32'(if0.regA));
        push("t6_busy_after", 0);   chk(32'(if0.busy));

        if (q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_multi.md
Name: reg_file_multi

Overview:
Parametrised successor to the 8x8 two-read/one-write register file, sitting in the datapath between decode and ALU operand muxes.
- Generalises data width and depth.
- Adds optional hardwired-zero register 0 and write-to-read bypass.
- Makes the flag bit sticky with an explicit clear.
- Adds a background clear-all sequencer: zeroes the array one entry per cycle while reporting busy.

Parameters:
DATA_W, 8, width of each register and of dataIn/regA/regB
ADDR_W, 3, address width; depth = 2**ADDR_W
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = an accepted same-cycle write is forwarded to matching read ports

Ports:
clock  input  1  single system clock, rising-edge
resetN  input  1  asynchronous active-low reset
enableWrite  input  1  write request this cycle
registerA  input  ADDR_W  read address, port A
registerB  input  ADDR_W  read address, port B
registerWrite  input  ADDR_W  write address
dataIn  input  DATA_W  write data
flag  input  1  set request for sticky flag
flagClear  input  1  clear request for sticky flag
clearAll  input  1  start clear-all sweep (sampled in IDLE only)
regA  output  DATA_W  read data, port A (combinational)
regB  output  DATA_W  read data, port B (combinational)
flagBit  output  1  sticky flag, registered
busy  output  1  high while the sweep is in progress
writeDropped  output  1  one-cycle pulse, cycle after a write refused by busy

Behaviour:
- Reset (resetN=0, asynchronous): all registers 0, flagBit=0, busy=0, writeDropped=0, FSM=IDLE, sweep counter=0. Reset mid-sweep aborts to IDLE.
- Write acceptance: enableWrite && !busy && !(ZERO_REG && registerWrite==0). Accepted write updates reg[registerWrite] on the rising edge; visible on reads from the next cycle.
- Reads are combinational: regX = reg[registerX].
  - ZERO_REG=1 and address 0: read returns 0.
  - BYPASS=1 and an accepted write to the same address this cycle: read returns dataIn. Both ports may bypass simultaneously.
- ZERO_REG write to address 0 is silently discarded; no writeDropped pulse.
- Flag: flagBit is registered. flag=1 sets it; flagClear=1 clears it; both high at once, set wins; neither, hold. The sweep does not touch flagBit.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP: edge with clearAll=1. Counter loads 0; busy rises on that edge.
  - SWEEP: each edge writes 0 to reg[counter], then counter++.
  - SWEEP -> IDLE: on the edge that clears entry 2**ADDR_W-1. busy falls on that edge. Sweep lasts exactly 2**ADDR_W cycles.
  - clearAll while in SWEEP is ignored (no restart).
- During SWEEP, reads return current array contents, whether already cleared or not. There is no bypass, because no write is accepted.
- During SWEEP, enableWrite=1 is refused. writeDropped=1 on the following cycle, for exactly one cycle per refused request.
- clearAll and enableWrite together in IDLE: the write is accepted (busy is still 0 that cycle). The sweep then clears that entry in due course.
- Address arithmetic is unsigned ADDR_W bits. The counter stops at its last value; it never wraps into a second pass.

Decomposition:
- reg_file_pkg: state enum (IDLE, SWEEP) and default parameter constants (DATA_W, ADDR_W).
- Sub-module clear_sequencer: owns FSM, counter, busy, and the clear-address/clear-enable outputs. The top level muxes its clear write against the user write.

Test Plan:
1. Reset, write 8'hCA to r1, then read A=r1 -> regA=8'hCA the cycle after the write edge. regB (address 0) = 8'h00.
2. BYPASS=1: enableWrite, registerWrite=4, dataIn=8'h56, registerA=registerB=4 in the same cycle -> regA=regB=8'h56 combinationally before the edge. With BYPASS=0 they show the old value 8'h00.
3. ZERO_REG=1: write 8'hFF to r0 -> regA(r0)=8'h00 and writeDropped stays 0. The same write to r2 reads 8'hFF.
4. Flag: flag=1 for one cycle -> flagBit=1 held after flag drops. flag=1 with flagClear=1 -> flagBit stays 1. flagClear alone -> flagBit=0 next edge.
5. Fill r0..r7 with 8'h10..8'h17, pulse clearAll:
   - busy is high for exactly 8 cycles.
   - Mid-sweep read of r7 returns 8'h17.
   - After busy falls, all reads return 8'h00.
   - A write issued mid-sweep is not applied, and writeDropped pulses once.
6. Assert resetN=0 on sweep cycle 3 -> busy=0 immediately and all registers 0. After release, a write to r5 is accepted the next cycle.
